// File: rtl/regfile_scoreboard.sv
// Register file with byte-lane writes, write-first read bypass,
// and a per-register pending-load scoreboard with population count.
//
// Ports:
//   clk, rst         clock, async active-low reset
//   rs_addr/rs_data  read port A (combinational)
//   rt_addr/rt_data  read port B (combinational)
//   wr_en/wr_addr    write strobe and address
//   wr_data/wr_be    write data and byte enables
//   wr_ld            write is a load writeback (clears pending)
//   ld_issue/ld_addr load issued; marks ld_addr pending
//   rs_busy/rt_busy  read address has a pending load
//   hazard           rs_busy | rt_busy
//   pend_count       number of pending registers (registered)
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   rs_addr,
  input  logic [ADDR_W-1:0]   rt_addr,
  output logic [DATA_W-1:0]   rs_data,
  output logic [DATA_W-1:0]   rt_data,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                wr_ld,
  input  logic                ld_issue,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic                rs_busy,
  output logic                rt_busy,
  output logic                hazard,
  output logic [ADDR_W:0]     pend_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [ADDR_W:0]   r_cnt;

  logic              w_wr_ok;
  logic              w_set;
  logic              w_clr;
  logic              w_inc;
  logic              w_dec;
  logic [DEPTH-1:0]  w_pend_nxt;
  logic              w_rs_hit;
  logic              w_rt_hit;
  logic              w_rs_zero;
  logic              w_rt_zero;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;

  function automatic logic [DATA_W-1:0] f_merge(
    input logic [DATA_W-1:0] old_d,
    input logic [DATA_W-1:0] new_d,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] m;
    m = old_d;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) m[b*8 +: 8] = new_d[b*8 +: 8];
    end
    return m;
  endfunction

  // Everything that mutates state is gated by rst so the
  // bypass paths also see nothing while reset is held.
  assign w_wr_ok = rst && wr_en &&
                   !(ZR && (wr_addr == '0));
  assign w_set   = rst && ld_issue &&
                   !(ZR && (ld_addr == '0));
  assign w_clr   = rst && wr_en && wr_ld;

  // Count delta: a set only adds if the bit was clear; a clear
  // only subtracts if the bit was set and no set overrides it.
  assign w_inc = w_set && !r_pend[ld_addr];
  assign w_dec = w_clr && r_pend[wr_addr] &&
                 !(w_set && (ld_addr == wr_addr));

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_clr) w_pend_nxt[wr_addr] = 1'b0;
    if (w_set) w_pend_nxt[ld_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          r_regs[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= r_cnt
              + {{ADDR_W{1'b0}}, w_inc}
              - {{ADDR_W{1'b0}}, w_dec};
    end
  end

  assign w_rs_zero = ZR && (rs_addr == '0);
  assign w_rt_zero = ZR && (rt_addr == '0);
  assign w_rs_hit  = w_wr_ok && (wr_addr == rs_addr);
  assign w_rt_hit  = w_wr_ok && (wr_addr == rt_addr);

  always_comb begin
    w_rs_data = '0;
    if (rst && !w_rs_zero) begin
      if (w_rs_hit) begin
        w_rs_data = f_merge(r_regs[rs_addr], wr_data, wr_be);
      end else begin
        w_rs_data = r_regs[rs_addr];
      end
    end
  end

  always_comb begin
    w_rt_data = '0;
    if (rst && !w_rt_zero) begin
      if (w_rt_hit) begin
        w_rt_data = f_merge(r_regs[rt_addr], wr_data, wr_be);
      end else begin
        w_rt_data = r_regs[rt_addr];
      end
    end
  end

  assign rs_data = w_rs_data;
  assign rt_data = w_rt_data;

  // A same-cycle load writeback hides the pending bit; a
  // same-cycle ld_issue is only visible after the edge.
  assign rs_busy = r_pend[rs_addr] &&
                   !(wr_en && wr_ld && (wr_addr == rs_addr));
  assign rt_busy = r_pend[rt_addr] &&
                   !(wr_en && wr_ld && (wr_addr == rt_addr));
  assign hazard  = rs_busy || rt_busy;

  assign pend_count = r_cnt;

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width (multiple of 8).
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 is hardwired zero.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, named as follows:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have the following ports:
- rs_addr  in  ADDR_W  read port A address.
- rt_addr  in  ADDR_W  read port B address.
- rs_data  out  DATA_W  read port A data.
- rt_data  out  DATA_W  read port B data.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables for the write.
- wr_ld  in  1  write is a load writeback; clears the pending bit.
- ld_issue  in  1  load issued; marks ld_addr pending.
- ld_addr  in  ADDR_W  destination of the issued load.
- rs_busy  out  1  rs_addr is pending.
- rt_busy  out  1  rt_addr is pending.
- hazard  out  1  rs_busy OR rt_busy.
- pend_count  out  ADDR_W+1  number of registers currently pending.

Function
REQ-006 Reads SHALL be combinational, with no clock latency.
REQ-007 A write SHALL update, at the clk edge, only the byte lanes whose wr_be bit is 1; other lanes SHALL keep their value.
REQ-008 If wr_en=1 and wr_addr equals a read address in the same cycle, that read SHALL return the merged old/new byte-lane value (write-first bypass).
REQ-009 With ZERO_REG=1:
- Reads of address 0 SHALL return 0.
- Writes to address 0 SHALL be ignored.
- ld_issue to address 0 SHALL NOT set a pending bit.
REQ-010 With ZERO_REG=0, address 0 SHALL behave as any other register.
REQ-011 The block SHALL hold one pending bit per register, updated on the clk edge:
- The bit SHALL be set when ld_issue=1 for ld_addr.
- The bit SHALL be cleared when wr_en=1 and wr_ld=1 for wr_addr.
REQ-012 If a set and a clear target the same address in the same cycle, set SHALL win; the bit stays or becomes 1.
REQ-013 wr_ld SHALL clear the pending bit even when wr_be is all zeros.
REQ-014 wr_en=1 with wr_ld=0 SHALL NOT modify pending bits.
REQ-015 ld_issue to an already pending address SHALL leave it pending, with pend_count unchanged.
REQ-016 Pending-bit bypass on the busy outputs:
- rs_busy SHALL equal pending[rs_addr] AND NOT (wr_en AND wr_ld AND wr_addr==rs_addr).
- rt_busy SHALL be defined likewise for rt_addr.
REQ-017 A same-cycle ld_issue SHALL NOT make rs_busy or rt_busy assert in that cycle; it takes effect from the next cycle.
REQ-018 hazard SHALL be combinational: rs_busy OR rt_busy.
REQ-019 pend_count SHALL equal the population count of the pending bits, registered.
REQ-020 pend_count SHALL reflect each edge's set and clear net effect, with a range of 0..2**ADDR_W and no wrap.

Reset
REQ-021 When rst=0, the block SHALL asynchronously clear all registers, all pending bits and pend_count to 0, independent of clk.
REQ-022 While rst=0, writes and ld_issue SHALL be ignored, and rs_data/rt_data SHALL read 0.
REQ-023 Reset asserted mid-operation SHALL discard all outstanding pending loads.
REQ-024 After rst deasserts, the first rising clk edge SHALL perform normal updates.

Verification
REQ-025 Reset then readback: after reset, read all 32 addresses -> every read returns 0x00000000; pend_count=0.
REQ-026 Byte-enable write with bypass:
- Stimulus: write r5=0xAABBCCDD with be=1111, then write r5=0x11223344 with be=0101 while rs_addr=5.
- Response: rs_data=0xAA22CC44 in the same cycle and after the edge.
REQ-027 Zero register:
- Stimulus: write r0=0xFFFFFFFF with be=1111, and ld_issue to r0.
- Response: rs_data(0)=0, rs_busy=0, pend_count=0.
REQ-028 Load scoreboard:
- Stimulus: ld_issue r7, then r9 in the next cycle.
- Response: pend_count=2 and hazard=1 with rt_addr=9.
- Stimulus: a cycle with wr_en=1, wr_ld=1, wr_addr=9.
- Response: rt_busy=0 in that cycle; pend_count=1 after the edge.
REQ-029 Simultaneous set and clear:
- Stimulus: r7 pending; same cycle ld_issue r7 and wr_ld write r7.
- Response: r7 still pending, pend_count unchanged, data updated.
REQ-030 Mid-operation reset:
- Stimulus: with 3 registers pending and nonzero data, pulse rst=0 between clk edges.
- Response: pend_count=0, hazard=0 and all reads 0 immediately.
